// File: rtl/booth_mult_arbiter_pkg.sv
// Shared types and helpers for the round-robin Booth multiplier arbiter.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ITER,
    DONE
  } booth_state_e;

  // Returns the first set bit of valid at or above ptr, wrapping at n (n <= 8).
  // Falls back to ptr when nothing is set; callers must qualify with valid.
  function automatic logic [2:0] rr_pick(input logic [7:0] valid,
                                         input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < 8; i++) begin
      idx = (32'(ptr) + i) % n;
      if (i < n && !found && valid[3'(idx)]) begin
        pick  = 3'(idx);
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/booth_mult_arbiter_seq_core.sv
// Sequential radix-2 Booth datapath: load latches operands, then one step per
// cycle until cnt reaches zero; p holds the signed product once done.
module booth_seq_core #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   acc;
  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] q;
  logic             b_n1;
  logic [CW-1:0]    cnt;

  // acc is one bit wider than the operands so that subtracting the most
  // negative multiplicand cannot overflow.
  always_comb begin
    sum = acc;
    case ({q[0], b_n1})
      2'b01:   sum = acc + a_ext;
      2'b10:   sum = acc - a_ext;
      default: sum = acc;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_ext <= '0;
      acc   <= '0;
      q     <= '0;
      b_n1  <= 1'b0;
      cnt   <= '0;
    end else if (load) begin
      a_ext <= {a[WIDTH-1], a};
      acc   <= '0;
      q     <= b;
      b_n1  <= 1'b0;
      cnt   <= CW'(WIDTH);
    end else if (cnt != '0) begin
      acc   <= {sum[WIDTH], sum[WIDTH:1]};
      q     <= {sum[0], q[WIDTH-1:1]};
      b_n1  <= q[0];
      cnt   <= cnt - 1'b1;
    end
  end

  assign last = (cnt == CW'(1));
  assign p    = {acc[WIDTH-1:0], q};

endmodule

// File: rtl/booth_mult_arbiter.sv
// Round-robin arbiter sharing one sequential Booth multiplier among N_REQ
// requesters. Define BOOTH_ARB_STATS_EN to add the ops_done counter port.
module booth_mult_arbiter
  import booth_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*WIDTH-1:0]     req_a,
  input  logic [N_REQ*WIDTH-1:0]     req_b,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic [2*WIDTH-1:0]         rsp_p
`ifdef BOOTH_ARB_STATS_EN
  ,
  output logic [15:0]                ops_done
`endif
);

  localparam int IDW = $clog2(N_REQ);

  booth_state_e     state_q, state_d;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   grant;
  logic [IDW-1:0]   next_ptr;
  logic [IDW-1:0]   id_q;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             accept;
  logic             core_last;

  assign grant    = IDW'(rr_pick(8'(req_valid), 3'(rr_ptr), N_REQ));
  assign next_ptr = (grant == IDW'(N_REQ - 1)) ? '0 : grant + 1'b1;
  assign sel_a    = req_a[32'(grant)*WIDTH +: WIDTH];
  assign sel_b    = req_b[32'(grant)*WIDTH +: WIDTH];

  always_comb begin
    state_d   = state_q;
    req_ready = '0;
    accept    = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (req_valid[grant]) begin
          req_ready[grant] = 1'b1;
          accept           = 1'b1;
          state_d          = ITER;
        end
      end
      ITER: begin
        if (core_last) state_d = DONE;
      end
      DONE: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_ptr  <= '0;
      id_q    <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        id_q   <= grant;
        rr_ptr <= next_ptr;
      end
    end
  end

  booth_seq_core #(
    .WIDTH (WIDTH)
  ) u_core (
    .clk  (clk),
    .rst  (rst),
    .load (accept),
    .a    (sel_a),
    .b    (sel_b),
    .last (core_last),
    .p    (rsp_p)
  );

  assign rsp_id = id_q;

`ifdef BOOTH_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ops_done <= '0;
    end else if (rsp_valid && rsp_ready && ops_done != 16'hFFFF) begin
      ops_done <= ops_done + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed bench for booth_mult_arbiter (N_REQ=4, WIDTH=4): product table,
// round-robin order, backpressure and reset-abort sequences.
module tb_booth_mult_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [15:0] req_a;
  logic [15:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_p;
`ifdef BOOTH_ARB_STATS_EN
  logic [15:0] ops_done;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  booth_mult_arbiter #(
    .N_REQ (4),
    .WIDTH (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_p     (rsp_p)
`ifdef BOOTH_ARB_STATS_EN
    ,
    .ops_done  (ops_done)
`endif
  );

  typedef struct {
    int         idx;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] p;
  } vec_t;

  vec_t tbl[9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, want);
    end
  endtask

  // Starts and ends on a negedge with rst deasserted.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Starts at a negedge in IDLE, ends at a negedge back in IDLE.
  task automatic run_op(input logic [3:0] mask, input int idx,
                        input logic [3:0] a, input logic [3:0] b,
                        input logic [7:0] want_p, input logic chk_lat);
    int lat;
    req_valid          = mask;
    req_a[idx*4 +: 4]  = a;
    req_b[idx*4 +: 4]  = b;
    #1;
    chk("grant", req_ready, 32'(4'b0001 << idx));
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    req_a     = 16'hA5C3;
    req_b     = 16'h3C5A;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (chk_lat) chk("latency", lat, 5);
    chk("rsp_p", rsp_p, want_p);
    chk("rsp_id", rsp_id, idx);
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    int lat;
    logic [7:0] rr_p [4];

    tbl[0] = '{0, 4'h3, 4'h5, 8'h0F};
    tbl[1] = '{1, 4'hD, 4'h5, 8'hF1};
    tbl[2] = '{2, 4'h8, 4'h8, 8'h40};
    tbl[3] = '{3, 4'h8, 4'h7, 8'hC8};
    tbl[4] = '{0, 4'h0, 4'hF, 8'h00};
    tbl[5] = '{1, 4'h7, 4'h7, 8'h31};
    tbl[6] = '{2, 4'hF, 4'hF, 8'h01};
    tbl[7] = '{3, 4'h5, 4'hD, 8'hF1};
    tbl[8] = '{0, 4'h7, 4'h8, 8'hC8};
    rr_p[0] = 8'h02; rr_p[1] = 8'h06; rr_p[2] = 8'h0C; rr_p[3] = 8'h14;

    rst = 1'b1; req_valid = '0; req_a = '0; req_b = '0; rsp_ready = 1'b1;
    @(negedge clk);
    do_reset();
    chk("reset_ready", req_ready, 0);
    chk("reset_valid", rsp_valid, 0);
    chk("reset_id", rsp_id, 0);
    chk("reset_p", rsp_p, 0);

    for (int i = 0; i < 9; i++)
      run_op(4'(1 << tbl[i].idx), tbl[i].idx, tbl[i].a, tbl[i].b, tbl[i].p, 1'b1);

    // Round robin with all requesters held valid.
    do_reset();
    req_a = {4'd4, 4'd3, 4'd2, 4'd1};
    req_b = {4'd5, 4'd4, 4'd3, 4'd2};
    req_valid = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("rr_grant", req_ready, 32'(4'b0001 << (k % 4)));
      @(posedge clk);
      lat = 0;
      do begin
        @(negedge clk);
        lat++;
      end while (!rsp_valid && lat < 20);
      chk("rr_id", rsp_id, k % 4);
      chk("rr_p", rsp_p, rr_p[k % 4]);
      @(posedge clk);
      @(negedge clk);
    end
    req_valid = '0;
    run_op(4'b0100, 2, 4'h3, 4'h3, 8'h09, 1'b0);
    run_op(4'b0100, 2, 4'hE, 4'h3, 8'hFA, 1'b0);
    repeat (4) @(negedge clk);
    req_b[3:0] = 4'h1;
    run_op(4'b0011, 0, 4'h6, 4'h1, 8'h06, 1'b0);

    // Backpressure: DONE held with a competing request pending.
    do_reset();
    req_valid = 4'b0010;
    req_a[7:4] = 4'h3;
    req_b[7:4] = 4'hE;
    #1;
    chk("bp_grant", req_ready, 4'b0010);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    req_valid = 4'b0001;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", rsp_valid, 1);
      chk("bp_p", rsp_p, 8'hFA);
      chk("bp_id", rsp_id, 1);
      chk("bp_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    #1;
    chk("bp_release_valid", rsp_valid, 0);
    chk("bp_release_ready", req_ready, 4'b0001);
    req_valid = '0;
    rsp_ready = 1'b1;
    @(negedge clk);

    // Reset during the second ITER cycle drops the operation and rr_ptr.
    req_valid = 4'b0100;
    req_a[11:8] = 4'h5;
    req_b[11:8] = 4'h5;
    #1;
    chk("abort_grant", req_ready, 4'b0100);
    @(posedge clk);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_rsp", seen, 0);
    req_a[15:12] = 4'h2;
    req_b[15:12] = 4'h2;
    run_op(4'b1010, 1, 4'h2, 4'h2, 8'h04, 1'b1);

`ifdef BOOTH_ARB_STATS_EN
    do_reset();
    run_op(4'b0001, 0, 4'h2, 4'h3, 8'h06, 1'b0);
    run_op(4'b0010, 1, 4'h2, 4'h3, 8'h06, 1'b0);
    run_op(4'b0100, 2, 4'h2, 4'h3, 8'h06, 1'b0);
    chk("ops_done", ops_done, 3);
    do_reset();
    chk("ops_done_reset", ops_done, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
